// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, request type and winner-source enum for the writeback stage
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // One pending register-file write: destination index plus result.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Which stream won the slot now presented on rf_write_*.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO buffering long-latency writeback requests
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push, wdata       enqueue request (ignored when full)
//   pop, rdata        dequeue; rdata is the current head (read-first)
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module wb_fifo
    import wb_pkg::*;
#(
    parameter type T     = wb_req_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and buffered long-latency results into one registered RF write per cycle
//
// Optional feature macro: WB_FORWARD_EN (adds decode bypass ports).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data         single-cycle ALU result stream
//   alu_ready                         ALU result accepted this cycle (combinational)
//   mem_valid/mem_rd/mem_data         long-latency result stream, buffered in a FIFO
//   mem_ready                         FIFO can accept (combinational)
//   rf_write_sel/data/en              registered register-file write port
//   fifo_count                        FIFO occupancy
//   fwd_selA/B, fwd_hitA/B, fwd_data  (WB_FORWARD_EN only) bypass of the pending write
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = wb_pkg::XLEN,
    parameter int REG_ADDR_W   = wb_pkg::REG_ADDR_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [REG_ADDR_W-1:0]         alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic [XLEN-1:0]               mem_data,
    output logic                          mem_ready,
    output logic [REG_ADDR_W-1:0]         rf_write_sel,
    output logic [XLEN-1:0]               rf_write_data,
    output logic                          rf_write_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0]         fwd_selA,
    input  logic [REG_ADDR_W-1:0]         fwd_selB,
    output logic                          fwd_hitA,
    output logic                          fwd_hitB,
    output logic [XLEN-1:0]               fwd_data
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } req_t;

    req_t     w_push_req;
    req_t     w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;
    logic     w_force;
    logic     w_alu_win;

    logic [SW-1:0] r_starve;
    wb_src_e       r_src;

    assign w_push_req = '{rd: mem_rd, data: mem_data};

    // A full FIFO refuses pushes even if it pops this cycle.
    assign mem_ready = !rst && !w_full;
    assign w_push    = mem_valid && mem_ready;

    assign w_force   = !w_empty && (w_full || (r_starve == SW'(STARVE_LIMIT)));
    assign w_alu_win = !rst && alu_valid && !w_force;
    assign alu_ready = w_alu_win;
    assign w_pop     = !rst && !w_empty && !w_alu_win;

    wb_fifo #(
        .T     (req_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_push_req),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src         <= SRC_NONE;
            rf_write_sel  <= '0;
            rf_write_data <= '0;
            r_starve      <= '0;
        end else begin
            if (w_alu_win) begin
                r_src         <= SRC_ALU;
                rf_write_sel  <= alu_rd;
                rf_write_data <= alu_data;
            end else if (w_pop) begin
                r_src         <= SRC_FIFO;
                rf_write_sel  <= w_head.rd;
                rf_write_data <= w_head.data;
            end else begin
                r_src <= SRC_NONE;
            end

            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (w_alu_win && (r_starve != SW'(STARVE_LIMIT))) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // Decoded purely from flops: a consumed x0 winner still updates sel to 0,
    // which suppresses the enable for that slot.
    assign rf_write_en = (r_src != SRC_NONE) && (rf_write_sel != '0);

`ifdef WB_FORWARD_EN
    assign fwd_hitA = rf_write_en && (rf_write_sel == fwd_selA) && (fwd_selA != '0);
    assign fwd_hitB = rf_write_en && (rf_write_sel == fwd_selB) && (fwd_selB != '0);
    assign fwd_data = rf_write_data;
`endif

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Writeback stage that sits directly upstream of the register file write port and is the sole driver of it. Merges two result streams, each with a valid/ready handshake, into one registered write per cycle:
- single-cycle ALU results;
- long-latency results (load/mul), which are buffered in a small FIFO.

Arbitration includes a starvation guard. Writes to x0 are filtered out.

Parameters:
XLEN, 32, data width
REG_ADDR_W, 5, register index width
FIFO_DEPTH, 4, long-latency buffer entries; power of 2, >=2
STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before it is forced

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result present
alu_rd  in  REG_ADDR_W  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU result accepted this cycle (combinational)
mem_valid  in  1  long-latency result present
mem_rd  in  REG_ADDR_W  long-latency destination register
mem_data  in  XLEN  long-latency result
mem_ready  out  1  FIFO can accept (combinational)
rf_write_sel  out  REG_ADDR_W  register file write index (registered)
rf_write_data  out  XLEN  register file write data (registered)
rf_write_en  out  1  register file write enable (registered)
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst high at posedge): FIFO emptied, starvation counter 0, rf_write_en=0, rf_write_sel=0, rf_write_data=0, fifo_count=0. Any in-flight FIFO entries are discarded.
- While rst is high: alu_ready=0 and mem_ready=0.
- mem_ready = (fifo_count < FIFO_DEPTH).
  - Push on mem_valid && mem_ready.
  - A simultaneous push and pop is legal at any occupancy below full.
  - Full is not relieved by a same-cycle pop: mem_ready stays 0.
- Arbitration per cycle, with force = FIFO non-empty && (fifo_count==FIFO_DEPTH || starve_cnt==STARVE_LIMIT):
  - force=1: FIFO head wins and alu_ready=0.
  - Otherwise, if alu_valid: ALU wins and alu_ready=1.
  - Otherwise, if FIFO non-empty: FIFO head wins (pop).
  - Otherwise: idle.
- Starvation counter:
  - Increments when FIFO is non-empty and the ALU wins.
  - Clears on any FIFO pop or when FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Latency: the winner accepted at posedge N drives rf_write_* for the whole cycle following N. Outputs are therefore stable across the negedge on which the register file captures.
- rd==0 filter: the winner is still consumed (handshake/pop occurs), but rf_write_en=0 for that slot.
- Idle cycle: rf_write_en=0; rf_write_sel and rf_write_data hold their previous values.
- Ordering: FIFO entries are written strictly in push order. No ordering is guaranteed between the ALU stream and the FIFO stream; the hazard unit upstream owns that.

Optional Feature:
WB_FORWARD_EN
- Defined: adds ports fwd_selA and fwd_selB (in, REG_ADDR_W) and fwd_hitA, fwd_hitB and fwd_data (out, 1/1/XLEN).
  - fwd_hitX = rf_write_en && rf_write_sel==fwd_selX && fwd_selX!=0.
  - fwd_data = rf_write_data.
  - Purely combinational from the registered outputs; lets decode bypass a write not yet visible in the register file.
- Undefined: these ports and their logic are absent. Decode must wait one cycle after a write before reading the register.

Decomposition:
- Package wb_pkg:
  - XLEN, REG_ADDR_W;
  - typedef wb_req_t {rd, data};
  - enum wb_src_e {SRC_NONE, SRC_ALU, SRC_FIFO} for the registered winner (debug visibility).
- Sub-module wb_fifo:
  - parameterised sync FIFO of wb_req_t;
  - push/pop/full/empty/count;
  - read-first head, pointer wrap at FIFO_DEPTH.

Test Plan:
1. ALU only: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready=1; next cycle rf_write_en=1, sel=5, data=0xDEADBEEF.
2. Simultaneous: ALU rd=10 data=0x12345678 and mem rd=15 data=0xAAAAAAAA -> ALU written first cycle; reg 15 written the following idle cycle; fifo_count returns to 0.
3. Starvation: ALU valid every cycle, one FIFO entry rd=7 -> ALU wins 4 cycles; 5th cycle alu_ready=0 and reg 7 written.
4. Full: 4 mem pushes with ALU continuously valid -> mem_ready=0 at count 4; next cycle FIFO forced, alu_ready=0; no data lost; FIFO entries written in push order.
5. x0: ALU rd=0 data=0xFFFFFFFF -> alu_ready=1, rf_write_en stays 0.
6. Reset mid-operation: 3 FIFO entries, assert rst one cycle -> fifo_count=0, rf_write_en=0, no stale entry written after release. With WB_FORWARD_EN, fwd_selA=5 during the test 1 write -> fwd_hitA=1, fwd_data=0xDEADBEEF.
